// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the program-counter fetch sequencer.
package pc_fetch_pkg;

  localparam int unsigned AW_DEF    = 8;
  localparam int unsigned CNT_W_DEF = 16;
  localparam logic [7:0]  RESET_PC_DEF = 8'h00;
  localparam logic [7:0]  PROG_END_DEF = 8'h1F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/pc_fetch_unit_next_sel.sv
// Next-PC priority mux: jump > branch > pending > sequential, plus branch adder.
module pc_next_sel #(
  parameter int unsigned AW = 8
) (
  input  logic [AW-1:0] pc_plus1,
  input  logic          jump,
  input  logic [AW-1:0] jump_target,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_off,
  input  logic          pend_valid,
  input  logic [AW-1:0] pend_pc,
  output logic [AW-1:0] next_pc,
  output logic          redirect_hit
);

  logic [AW-1:0] branch_pc;

  // Two's-complement offset relative to pc+1; overflow wraps.
  assign branch_pc    = pc_plus1 + branch_off;
  assign redirect_hit = jump | branch_taken;

  always_comb begin
    next_pc = pc_plus1;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_pc;
    end else if (pend_valid) begin
      next_pc = pend_pc;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter sequencer feeding the 8-bit datapath (IDLE/RUN/STALL/HALT).
// Optional PC_LIMIT_EN: halt at PROG_END or on a redirect beyond it.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int unsigned     AW       = AW_DEF,
  parameter logic [AW-1:0]   RESET_PC = AW'(RESET_PC_DEF),
  parameter logic [AW-1:0]   PROG_END = AW'(PROG_END_DEF),
  parameter int unsigned     CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             jump,
  input  logic [AW-1:0]    jump_target,
  input  logic             branch_taken,
  input  logic [AW-1:0]    branch_off,
  input  logic             halt_req,
  output logic [AW-1:0]    pc_out,
  output logic [AW-1:0]    pc_plus1,
  output logic             pc_valid,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt
);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_d;
  logic          pend_valid_q, pend_valid_d;
  logic [AW-1:0] pend_pc_q, pend_pc_d;
  logic          cnt_inc;
  logic [AW-1:0] next_pc;
  logic          redirect_hit;

  assign pc_plus1 = pc_out + AW'(1);

  pc_next_sel #(.AW(AW)) u_next_sel (
    .pc_plus1     (pc_plus1),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .pend_valid   (pend_valid_q),
    .pend_pc      (pend_pc_q),
    .next_pc      (next_pc),
    .redirect_hit (redirect_hit)
  );

`ifdef PC_LIMIT_EN
  logic limit_stop;
  // Sequential step off PROG_END, or any redirect past it, ends the program.
  assign limit_stop = (redirect_hit || pend_valid_q) ? (next_pc > PROG_END)
                                                     : (pc_out == PROG_END);
`else
  logic limit_stop;
  logic unused_prog_end;
  assign limit_stop      = 1'b0;
  assign unused_prog_end = ^PROG_END;
`endif

  // Next-state, next-PC and pending-redirect selection.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_out;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    cnt_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        cnt_inc = ~stall;
        if (halt_req) begin
          state_d      = HALT;
          pend_valid_d = 1'b0;
        end else if (stall) begin
          state_d = STALL;
          if (redirect_hit) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = next_pc;
          end
        end else if (limit_stop) begin
          state_d      = HALT;
          pend_valid_d = 1'b0;
        end else begin
          pc_d         = next_pc;
          pend_valid_d = 1'b0;
        end
      end
      STALL: begin
        // PC holds on the STALL->RUN edge so the stalled instruction re-issues.
        if (halt_req) begin
          state_d      = HALT;
          pend_valid_d = 1'b0;
        end else begin
          if (redirect_hit) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = next_pc;
          end
          if (!stall) state_d = RUN;
        end
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
  end

  // State, PC, pending, status flags and saturating retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_out       <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      pc_valid     <= 1'b0;
      halted       <= 1'b0;
      retired_cnt  <= '0;
    end else begin
      state_q      <= state_d;
      pc_out       <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      pc_valid     <= (state_d == RUN);
      halted       <= (state_d == HALT);
      if (cnt_inc && (retired_cnt != {CNT_W{1'b1}})) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed cycles push expectations, a monitor checks them.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, start, stall, jump, branch_taken, halt_req;
  logic [7:0]  jump_target, branch_off;
  logic [7:0]  pc_out, pc_plus1;
  logic        pc_valid, halted;
  logic [15:0] retired_cnt;

  typedef struct {
    string       name;
    logic [7:0]  pc;
    logic        valid;
    logic        hlt;
    logic        chk_cnt;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.PROG_END(8'h05)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .halt_req     (halt_req),
    .pc_out       (pc_out),
    .pc_plus1     (pc_plus1),
    .pc_valid     (pc_valid),
    .halted       (halted),
    .retired_cnt  (retired_cnt)
  );

  // Monitor: one expected entry per clock edge, checked 1 ns after the edge.
  initial begin
    exp_t e;
    logic [7:0] exp_p1;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_p1 = e.pc + 8'd1;
        checks++;
        if (pc_out !== e.pc || pc_plus1 !== exp_p1 || pc_valid !== e.valid ||
            halted !== e.hlt || (e.chk_cnt && retired_cnt !== e.cnt)) begin
          errors++;
          $display("FAIL %s: got pc=%02h p1=%02h v=%0b h=%0b cnt=%0d, want pc=%02h p1=%02h v=%0b h=%0b cnt=%0d(chk=%0b)",
                   e.name, pc_out, pc_plus1, pc_valid, halted, retired_cnt,
                   e.pc, exp_p1, e.valid, e.hlt, e.cnt, e.chk_cnt);
        end
      end
    end
  end

  task automatic clr();
    reset = 0; start = 0; stall = 0; jump = 0; branch_taken = 0; halt_req = 0;
    jump_target = 8'h00; branch_off = 8'h00;
  endtask

  // Apply current inputs across one edge and record the state expected after it.
  task automatic tick(input string nm, input logic [7:0] pc, input logic v,
                      input logic h, input logic cc = 1'b0, input logic [15:0] cnt = 16'd0);
    exp_t e;
    @(posedge clk);
    e.name = nm; e.pc = pc; e.valid = v; e.hlt = h; e.chk_cnt = cc; e.cnt = cnt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    clr();
    @(negedge clk);

    // T1: reset, start, five sequential fetches
    reset = 1; tick("t1_reset", 8'h00, 0, 0, 1, 16'd0);
    clr(); start = 1; tick("t1_start", 8'h00, 1, 0, 1, 16'd0);
    clr();
    for (int i = 1; i <= 5; i++) tick("t1_seq", 8'(i), 1, 0, 1, 16'(i));

    // T2: negative branch, then jump beats branch
    reset = 1; tick("t2_reset", 8'h00, 0, 0);
    clr(); start = 1; tick("t2_start", 8'h00, 1, 0);
    clr();
    for (int i = 1; i <= 3; i++) tick("t2_seq", 8'(i), 1, 0);
    branch_taken = 1; branch_off = 8'hFE; tick("t2_branch_back", 8'h02, 1, 0);
    jump = 1; jump_target = 8'h10; tick("t2_jump_wins", 8'h10, 1, 0);
    clr(); tick("t2_after", 8'h11, 1, 0);

    // T3: stall with redirect captured in the 2nd stall clock
    jump = 1; jump_target = 8'h04; tick("t3_goto04", 8'h04, 1, 0);
    clr(); stall = 1; tick("t3_stall1", 8'h04, 0, 0);
    jump = 1; jump_target = 8'h20; tick("t3_stall2", 8'h04, 0, 0);
    jump = 0; tick("t3_stall3", 8'h04, 0, 0);
    clr(); tick("t3_reissue04", 8'h04, 1, 0);
    tick("t3_pending", 8'h20, 1, 0);
    tick("t3_after", 8'h21, 1, 0);

    // T4: halt freezes PC, ignores start/jump; reset (with start/jump high) wins
    jump = 1; jump_target = 8'h07; tick("t4_goto07", 8'h07, 1, 0);
    clr(); halt_req = 1; tick("t4_halt", 8'h07, 0, 1);
    clr(); start = 1; jump = 1; jump_target = 8'h33;
    for (int i = 0; i < 10; i++) tick("t4_hold", 8'h07, 0, 1);
    reset = 1; tick("t4_reset", 8'h00, 0, 0);
    clr(); tick("t4_idle", 8'h00, 0, 0);

    // T5: reset mid-stall drops the pending redirect
    start = 1; tick("t5_start", 8'h00, 1, 0);
    clr(); tick("t5_seq", 8'h01, 1, 0);
    stall = 1; tick("t5_stall", 8'h01, 0, 0);
    jump = 1; jump_target = 8'h40; tick("t5_capture", 8'h01, 0, 0);
    clr(); reset = 1; tick("t5_reset", 8'h00, 0, 0);
    clr(); start = 1; tick("t5_restart", 8'h00, 1, 0);
    clr(); tick("t5_no_pending", 8'h01, 1, 0);
    tick("t5_seq2", 8'h02, 1, 0);

`ifndef PC_LIMIT_EN
    // T6: sequential wrap from FF to 00
    jump = 1; jump_target = 8'hFF; tick("t6_goto_ff", 8'hFF, 1, 0);
    clr(); tick("t6_wrap", 8'h00, 1, 0);
    tick("t6_after", 8'h01, 1, 0);
`else
    // T6: run to PROG_END=05 and halt there
    reset = 1; tick("t6_reset", 8'h00, 0, 0);
    clr(); start = 1; tick("t6_start", 8'h00, 1, 0);
    clr();
    for (int i = 1; i <= 5; i++) tick("t6_seq", 8'(i), 1, 0);
    tick("t6_limit", 8'h05, 0, 1);
    tick("t6_hold", 8'h05, 0, 1);
`endif

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
